// File: rtl/periph_bus_if.sv
// CPU data-bus view of the peripheral block: strobes, address and data in, read data and
// window-hit flag out.
interface periph_bus_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output rd, output wr, output addr, output wdata, input rdata, input hit);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata, output hit);
endinterface

// File: rtl/periph_bus.sv
// Memory-mapped peripherals: reloadable interrupt timer, LEDs, synchronised switches,
// 7-segment digit register and a free-running system tick, in a 32-byte window.
module periph_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned SW_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    periph_bus_if.slave         bus,
    output logic                irqout,
    output logic [SW_WIDTH-1:0] led,
    output logic [11:0]         digi,
    input  logic [SW_WIDTH-1:0] switch
);

    logic [31:0]         th_q, th_d;
    logic [31:0]         tl_q, tl_d;
    logic [2:0]          tcon_q, tcon_d;
    logic [SW_WIDTH-1:0] led_q, led_d;
    logic [11:0]         digi_q, digi_d;
    logic [31:0]         systick_q;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;

    logic       we;
    logic [2:0] sel;
    logic       overflow;
    logic       unused_addr;

    assign bus.hit     = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign we          = bus.wr && bus.hit;
    assign sel         = bus.addr[4:2];
    assign unused_addr = ^bus.addr[1:0];
    assign overflow    = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;

        // Reload takes the pre-edge TH, so a TH write in the overflow cycle applies next time.
        if (tcon_q[0]) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        tcon_d[2] = tcon_q[2] | (overflow & tcon_q[1]);

        if (we) begin
            unique case (sel)
                3'd0: th_d = bus.wdata;
                3'd1: tl_d = bus.wdata;
                3'd2: begin
                    // An overflow on this edge still raises status, gated by the new irq enable.
                    tcon_d[1:0] = bus.wdata[1:0];
                    tcon_d[2]   = bus.wdata[2] | (overflow & bus.wdata[1]);
                end
                3'd3: led_d  = bus.wdata[SW_WIDTH-1:0];
                3'd5: digi_d = bus.wdata[11:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_q + 32'd1;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && bus.hit) begin
            unique case (sel)
                3'd0: bus.rdata = th_q;
                3'd1: bus.rdata = tl_q;
                3'd2: bus.rdata = {29'd0, tcon_q};
                3'd3: bus.rdata = 32'(led_q);
                3'd4: bus.rdata = 32'(sw_sync_q);
                3'd5: bus.rdata = {20'd0, digi_q};
                3'd6: bus.rdata = systick_q;
                default: bus.rdata = '0;
            endcase
        end
    end

    assign irqout = tcon_q[1] & tcon_q[2];
    assign led    = led_q;
    assign digi   = digi_q;

endmodule

// File: doc/periph_bus.md
Name: periph_bus

Overview:
- Memory-mapped peripheral block on the CPU data bus. It sits alongside the data memory and is driven by the same rd/wr/addr/wdata from the execute/memory stage.
- Provides a reloadable interrupt timer, an LED register, a synchronised switch input, a 7-segment digit register and a free-running system tick counter.
- Asserts `hit` for addresses in its window. The CPU uses `hit` to select this block's `rdata` over the data-memory `rdata`.

Parameters:
- BASE_ADDR, 32'h40000000, word-aligned base of the 32-byte register window.
- SW_WIDTH, 8, width of the switch input and of the LED register.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
- rd  input  1  read strobe
- wr  input  1  write strobe; acts on rising edge
- addr  input  32  byte address; bits [1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data (combinational)
- hit  output  1  addr[31:5] == BASE_ADDR[31:5]
- irqout  output  1  timer interrupt request to the CPU
- led  output  SW_WIDTH  LED register value
- digi  output  12  7-segment register value
- switch  input  SW_WIDTH  asynchronous board switches

Behaviour:
- Register map, as offset from BASE_ADDR (selected by addr[4:2]):
  - 0x00 TH: timer reload value, R/W
  - 0x04 TL: timer counter, R/W
  - 0x08 TCON[2:0]: bit0 = enable, bit1 = irq enable, bit2 = irq status; R/W
  - 0x0C LED: R/W
  - 0x10 SWITCH: read-only
  - 0x14 DIGI[11:0]: R/W
  - 0x18 SYSTICK: read-only
  - 0x1C: reserved; reads 0, writes ignored
- Reset (synchronous): the following all go to 0 on the first clk edge with reset=1, regardless of wr:
  - TH, TL, TCON, LED, DIGI, SYSTICK
  - both switch synchroniser stages
  - therefore led = 0, digi = 0, irqout = 0
- Reset mid-count aborts the count. A pending irq is cleared.
- Read:
  - rdata = selected register, zero-extended, when rd && hit; otherwise 32'h0.
  - Same-cycle combinational read with no latency. A read returns the pre-edge value.
- Write: when wr && hit, the register is updated at the clk edge.
  - Upper bits beyond a register's width are discarded.
  - Writes to SWITCH, SYSTICK and 0x1C have no effect.
  - wr with hit=0 changes nothing.
- SYSTICK: increments by 1 every non-reset cycle and wraps 32'hFFFFFFFF -> 0.
- Switch sync:
  - Two-flop synchroniser.
  - A switch change before edge N is visible in a SWITCH read after edge N+1.
- Timer, each cycle with TCON[0] = 1:
  - If TL != 32'hFFFFFFFF: TL <= TL + 1.
  - If TL == 32'hFFFFFFFF: TL <= TH (reload, no intermediate 0). If TCON[1] = 1, TCON[2] <= 1 on the same edge.
  - When TCON[0] = 0, TL holds.
- irqout = TCON[1] & TCON[2]. This is combinational from the register, so it is high in the cycle after the overflow edge.
- irq clear: software writes TCON with bit2 = 0. TCON[2] is sticky until then.
- Simultaneous events:
  - A CPU write to TL beats the increment/reload in the same cycle.
  - A CPU write to TH in the overflow cycle: the reload uses the old TH, and the new TH applies from the next overflow.
  - A TCON write in the overflow cycle: bits [1:0] take wdata. Bit2 becomes 1 if the overflow sets it, using the new bit1 value; otherwise it takes wdata[2]. No interrupt is lost.
- rd and wr in the same cycle are legal. rdata shows the old value.

Test Plan:
- Reset: after writing all registers, assert reset for 1 edge -> every readback is 0, led = 0, digi = 0, irqout = 0.
- Overflow and reload:
  - Setup: write TH = 32'hFFFFFFFC, TL = 32'hFFFFFFFE, TCON = 3'b011.
  - Required: TL reads FFFFFFFF after 1 edge and FFFFFFFC after 2 edges. irqout is 1 from the cycle after the 2nd edge.
  - Then write TCON = 3'b011 -> irqout = 0 on the next cycle.
- Disabled timer: TCON = 3'b000, TL = 5, run 10 cycles -> TL reads 5 and irqout stays 0. Then TCON = 3'b001 -> TL reads 6 after 1 edge.
- Write collision:
  - Timer running at TL = FFFFFFFF with TCON = 3'b011. In the same cycle, write TCON = 3'b011 (bit2 clear).
  - Required: TCON reads 3'b111 and irqout = 1.
  - Separately, a TL write of 32'h10 while counting -> TL reads 32'h10, not 11.
- Bus decode:
  - Write 0xA5 to offset 0x0C -> led = 8'hA5.
  - wr to 32'h00000010 (hit = 0) -> no register changes.
  - Read at 0x1C -> 0. Read with rd = 0 -> 0.
- Switch/systick:
  - Switch 8'h3C applied before edge N -> SWITCH reads old value until edge N+1, then 32'h3C.
  - Two SYSTICK reads 7 cycles apart differ by 7. Preload via reset-then-count to FFFFFFFF -> the next read is 0.
